vga_dither_out: RTL and testbench

- Final colour stage between the shader layer and the VGA DAC pins.
- Takes the shader's 8-bit-per-channel colour plus raster position and syncs. Reduces colour to the board's RGB332 pins with a 4x4 ordered (Bayer) dither, optionally rotated per frame for temporal dither.
- Delays hsync/vsync so they stay aligned with the colour.
- Runs on the system clock; the pipeline advances only on the pixel-enable strobe (1 in 3 clocks for 800x600@60).

---
 rtl/vga_dither_out_if.sv | 28 ++
 rtl/vga_dither_out.sv | 96 +++++++++
 tb/tb_vga_dither_out.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vga_dither_out_if.sv
// Pixel bus between the shader/timing stage and the dither output stage.
// The master drives colour, position and syncs. The slave returns the DAC pins and the frame counter.
interface vga_dither_out_if;
  logic       pix_en;
  logic       active_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] x_in;
  logic [1:0] y_in;
  logic [7:0] red_in;
  logic [7:0] green_in;
  logic [7:0] blue_in;
  logic [2:0] red_F;
  logic [2:0] green_F;
  logic [1:0] blue_F;
  logic       hsync;
  logic       vsync;
  logic [3:0] frame_cnt;

  modport master (
    output pix_en, active_in, hsync_in, vsync_in, x_in, y_in, red_in, green_in, blue_in,
    input  red_F, green_F, blue_F, hsync, vsync, frame_cnt
  );
  modport slave (
    input  pix_en, active_in, hsync_in, vsync_in, x_in, y_in, red_in, green_in, blue_in,
    output red_F, green_F, blue_F, hsync, vsync, frame_cnt
  );
endinterface

// File: rtl/vga_dither_out.sv
// RGB888 -> RGB332 output stage with a 4x4 ordered dither (optionally rotated per frame).
// The two-stage pipeline advances on pix_en. Syncs travel alongside the colour.
module vga_dither_out #(
  parameter logic DITHER_EN       = 1'b1,
  parameter logic TEMPORAL        = 1'b1,
  parameter logic SYNC_ACTIVE_LOW = 1'b1
) (
  input logic              clock,
  input logic              reset_n,
  vga_dither_out_if.slave  bus
);
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: bayer = 4'd0;  4'h1: bayer = 4'd8;  4'h2: bayer = 4'd2;  4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12; 4'h5: bayer = 4'd4;  4'h6: bayer = 4'd14; 4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;  4'h9: bayer = 4'd11; 4'hA: bayer = 4'd1;  4'hB: bayer = 4'd9;
      4'hC: bayer = 4'd15; 4'hD: bayer = 4'd7;  4'hE: bayer = 4'd13; default: bayer = 4'd5;
    endcase
  endfunction

  logic [3:0] r_frame_cnt;
  logic       r_vs_prev;
  logic       r1_active, r1_hs, r1_vs;
  logic [7:0] r1_red, r1_green, r1_blue;
  logic [3:0] r1_t;
  logic [2:0] r_red, r_green;
  logic [1:0] r_blue;
  logic       r_hs, r_vs;

  logic [1:0] w_col, w_row;
  logic [3:0] w_t;
  logic       w_vs_edge;
  logic [8:0] w_sum_r, w_sum_g, w_sum_b;
  logic       w_unused;

  // The index uses the pre-increment frame count, so a pixel that lands on the vsync edge keeps the old pattern.
  assign w_col     = TEMPORAL ? bus.x_in + r_frame_cnt[1:0] : bus.x_in;
  assign w_row     = TEMPORAL ? bus.y_in + r_frame_cnt[3:2] : bus.y_in;
  assign w_t       = DITHER_EN ? bayer(w_row, w_col) : 4'd0;
  assign w_vs_edge = (r_vs_prev == SYNC_IDLE) && (bus.vsync_in != SYNC_IDLE);

  // The sum is 9 bits wide, so bit 8 flags overflow past 255.
  assign w_sum_r = {1'b0, r1_red}   + {4'b0, r1_t, 1'b0};
  assign w_sum_g = {1'b0, r1_green} + {4'b0, r1_t, 1'b0};
  assign w_sum_b = {1'b0, r1_blue}  + {3'b0, r1_t, 2'b0};
  assign w_unused = ^{w_sum_r[4:0], w_sum_g[4:0], w_sum_b[5:0]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_frame_cnt <= 4'd0;
      r_vs_prev   <= SYNC_IDLE;
      r1_active   <= 1'b0;
      r1_hs       <= SYNC_IDLE;
      r1_vs       <= SYNC_IDLE;
      r1_red      <= 8'd0;
      r1_green    <= 8'd0;
      r1_blue     <= 8'd0;
      r1_t        <= 4'd0;
      r_red       <= 3'd0;
      r_green     <= 3'd0;
      r_blue      <= 2'd0;
      r_hs        <= SYNC_IDLE;
      r_vs        <= SYNC_IDLE;
    end else if (bus.pix_en) begin
      r_vs_prev <= bus.vsync_in;
      if (w_vs_edge) r_frame_cnt <= r_frame_cnt + 4'd1;
      r1_active <= bus.active_in;
      r1_hs     <= bus.hsync_in;
      r1_vs     <= bus.vsync_in;
      r1_red    <= bus.red_in;
      r1_green  <= bus.green_in;
      r1_blue   <= bus.blue_in;
      r1_t      <= w_t;
      r_hs      <= r1_hs;
      r_vs      <= r1_vs;
      if (r1_active) begin
        r_red   <= w_sum_r[8] ? 3'b111 : w_sum_r[7:5];
        r_green <= w_sum_g[8] ? 3'b111 : w_sum_g[7:5];
        r_blue  <= w_sum_b[8] ? 2'b11  : w_sum_b[7:6];
      end else begin
        r_red   <= 3'd0;
        r_green <= 3'd0;
        r_blue  <= 2'd0;
      end
    end
  end

  assign bus.red_F     = r_red;
  assign bus.green_F   = r_green;
  assign bus.blue_F    = r_blue;
  assign bus.hsync     = r_hs;
  assign bus.vsync     = r_vs;
  assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_vga_dither_out.sv
// Directed bench: three instances (plain truncation, static dither, temporal dither) driven in lockstep.
module tb_vga_dither_out;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en = 1'b0, active_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [1:0] x_in = '0, y_in = '0;
  logic [7:0] red_in = '0, green_in = '0, blue_in = '0;
  logic [2:0] rF[3];
  logic [2:0] gF[3];
  logic [1:0] bF[3];
  logic       hs[3];
  logic       vs[3];
  logic [3:0] fc[3];
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  vga_dither_out_if ifs[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].pix_en    = pix_en;
    assign ifs[g].active_in = active_in;
    assign ifs[g].hsync_in  = hsync_in;
    assign ifs[g].vsync_in  = vsync_in;
    assign ifs[g].x_in      = x_in;
    assign ifs[g].y_in      = y_in;
    assign ifs[g].red_in    = red_in;
    assign ifs[g].green_in  = green_in;
    assign ifs[g].blue_in   = blue_in;
    vga_dither_out #(.DITHER_EN(g != 0), .TEMPORAL(g == 2), .SYNC_ACTIVE_LOW(1'b1)) u_dut (
      .clock(clock), .reset_n(reset_n), .bus(ifs[g])
    );
    assign rF[g] = ifs[g].red_F;
    assign gF[g] = ifs[g].green_F;
    assign bF[g] = ifs[g].blue_F;
    assign hs[g] = ifs[g].hsync;
    assign vs[g] = ifs[g].vsync;
    assign fc[g] = ifs[g].frame_cnt;
  end

  task automatic set_pix(input logic act, input logic h, input logic v, input logic [1:0] x,
                         input logic [1:0] y, input logic [7:0] r, input logic [7:0] gr, input logic [7:0] b);
    active_in = act; hsync_in = h; vsync_in = v; x_in = x; y_in = y;
    red_in = r; green_in = gr; blue_in = b;
  endtask

  // One strobe followed by a 2-clock gap; returns on a falling edge.
  task automatic strobe();
    pix_en = 1'b1;
    @(negedge clock);
    pix_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pix_en = 1'b1;
    set_pix(1, 0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clock); @(negedge clock);
    pix_en = 1'b0; reset_n = 1'b1;
    set_pix(1, 1, 1, 0, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) begin
      tests++; if ({rF[g], gF[g], bF[g]} !== 8'd0) begin fails++; $display("FAIL reset_colour dut%0d got %h exp 00", g, {rF[g], gF[g], bF[g]}); end
      tests++; if ({hs[g], vs[g]} !== 2'b11) begin fails++; $display("FAIL reset_sync dut%0d got %b exp 11", g, {hs[g], vs[g]}); end
      tests++; if (fc[g] !== 4'd0) begin fails++; $display("FAIL reset_fc dut%0d got %0d exp 0", g, fc[g]); end
    end
  endtask

  task automatic test_plain();
    set_pix(1, 1, 1, 0, 0, 8'hE0, 8'h5F, 8'hC0);
    strobe();
    tests++; if (rF[0] !== 3'd0) begin fails++; $display("FAIL plain_latency got %0d exp 0", rF[0]); end
    set_pix(1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    strobe();
    tests++; if ({rF[0], gF[0], bF[0]} !== {3'd7, 3'd2, 2'd3}) begin fails++; $display("FAIL plain_rgb got %0d/%0d/%0d exp 7/2/3", rF[0], gF[0], bF[0]); end
    @(negedge clock); @(negedge clock);
    tests++; if ({rF[0], gF[0], bF[0]} !== {3'd7, 3'd2, 2'd3}) begin fails++; $display("FAIL plain_hold got %0d/%0d/%0d exp 7/2/3", rF[0], gF[0], bF[0]); end
  endtask

  task automatic test_dither_static();
    set_pix(1, 1, 1, 0, 0, 8'h10, 8'h00, 8'h00);
    strobe();
    set_pix(1, 1, 1, 1, 0, 8'h10, 8'h00, 8'h00);
    strobe();
    tests++; if (rF[1] !== 3'd0) begin fails++; $display("FAIL dither_x0 got %0d exp 0", rF[1]); end
    set_pix(1, 1, 1, 3, 0, 8'h10, 8'h00, 8'h30);
    strobe();
    tests++; if (rF[1] !== 3'd1) begin fails++; $display("FAIL dither_x1 got %0d exp 1", rF[1]); end
    tests++; if (rF[0] !== 3'd0) begin fails++; $display("FAIL trunc_x1 got %0d exp 0", rF[0]); end
    set_pix(1, 1, 1, 3, 1, 8'hFF, 8'hFF, 8'hFF);
    strobe();
    tests++; if (bF[1] !== 2'd1) begin fails++; $display("FAIL dither_blue got %0d exp 1", bF[1]); end
    set_pix(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    strobe();
    tests++; if ({rF[1], gF[1], bF[1]} !== {3'd7, 3'd7, 2'd3}) begin fails++; $display("FAIL sat_static got %0d/%0d/%0d exp 7/7/3", rF[1], gF[1], bF[1]); end
    tests++; if ({rF[2], gF[2], bF[2]} !== {3'd7, 3'd7, 2'd3}) begin fails++; $display("FAIL sat_temporal got %0d/%0d/%0d exp 7/7/3", rF[2], gF[2], bF[2]); end
  endtask

  task automatic test_frame_cnt();
    set_pix(1, 1, 0, 0, 0, 8'h10, 8'h00, 8'h00);
    strobe();
    tests++; if (fc[2] !== 4'd1) begin fails++; $display("FAIL fc_first_edge got %0d exp 1", fc[2]); end
    tests++; if (vs[2] !== 1'b1) begin fails++; $display("FAIL vsync_early got %b exp 1", vs[2]); end
    strobe();
    tests++; if (rF[2] !== 3'd0) begin fails++; $display("FAIL edge_pixel_old_fc got %0d exp 0", rF[2]); end
    tests++; if (vs[2] !== 1'b0) begin fails++; $display("FAIL vsync_aligned got %b exp 0", vs[2]); end
    strobe();
    tests++; if (rF[2] !== 3'd1) begin fails++; $display("FAIL temporal_fc1 got %0d exp 1", rF[2]); end
    tests++; if (rF[1] !== 3'd0) begin fails++; $display("FAIL static_fc1 got %0d exp 0", rF[1]); end
    strobe();
    tests++; if (fc[2] !== 4'd1) begin fails++; $display("FAIL fc_held_low got %0d exp 1", fc[2]); end
    set_pix(0, 1, 1, 0, 0, 0, 0, 0);
    strobe();
    vsync_in = 1'b0;
    strobe();
    tests++; if (fc[2] !== 4'd2) begin fails++; $display("FAIL fc_second_edge got %0d exp 2", fc[2]); end
    for (int i = 0; i < 13; i++) begin
      vsync_in = 1'b1; strobe();
      vsync_in = 1'b0; strobe();
    end
    tests++; if (fc[2] !== 4'd15) begin fails++; $display("FAIL fc_15 got %0d exp 15", fc[2]); end
    vsync_in = 1'b1; strobe();
    vsync_in = 1'b0; strobe();
    tests++; if (fc[2] !== 4'd0) begin fails++; $display("FAIL fc_wrap got %0d exp 0", fc[2]); end
    vsync_in = 1'b1; strobe();
  endtask

  task automatic test_blank_sync();
    set_pix(1, 1, 1, 0, 0, 8'hFF, 8'h00, 8'h00);
    strobe();
    set_pix(0, 0, 1, 0, 0, 8'hFF, 8'h00, 8'h00);
    strobe();
    tests++; if ({rF[0], hs[0]} !== {3'd7, 1'b1}) begin fails++; $display("FAIL pre_blank got r=%0d hs=%b exp r=7 hs=1", rF[0], hs[0]); end
    set_pix(1, 1, 1, 0, 0, 8'hFF, 8'h00, 8'h00);
    strobe();
    tests++; if ({rF[0], hs[0]} !== {3'd0, 1'b0}) begin fails++; $display("FAIL blank_plain got r=%0d hs=%b exp r=0 hs=0", rF[0], hs[0]); end
    tests++; if ({rF[2], hs[2]} !== {3'd0, 1'b0}) begin fails++; $display("FAIL blank_temporal got r=%0d hs=%b exp r=0 hs=0", rF[2], hs[2]); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      set_pix(1, 1, (i % 2) != 0, 2'(i), 0, 8'hFF, 8'hFF, 8'hFF);
      strobe();
    end
    tests++; if (fc[0] !== 4'd5) begin fails++; $display("FAIL fc_pre_reset got %0d exp 5", fc[0]); end
    reset_n = 1'b0; pix_en = 1'b1;
    @(negedge clock);
    reset_n = 1'b1; pix_en = 1'b0;
    tests++; if ({rF[0], gF[0], bF[0], hs[0], vs[0], fc[0]} !== {8'd0, 2'b11, 4'd0}) begin fails++; $display("FAIL mid_reset got r=%0d g=%0d b=%0d hs=%b vs=%b fc=%0d exp 0/0/0/1/1/0", rF[0], gF[0], bF[0], hs[0], vs[0], fc[0]); end
    set_pix(1, 0, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    strobe();
    tests++; if ({rF[0], hs[0]} !== {3'd0, 1'b1}) begin fails++; $display("FAIL post_reset_1 got r=%0d hs=%b exp r=0 hs=1", rF[0], hs[0]); end
    strobe();
    tests++; if ({rF[0], hs[0]} !== {3'd7, 1'b0}) begin fails++; $display("FAIL post_reset_2 got r=%0d hs=%b exp r=7 hs=0", rF[0], hs[0]); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_plain();
    test_dither_static();
    test_frame_cnt();
    test_blank_sync();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end
endmodule
